// File: rtl/fpu_seq_pkg.sv
`default_nettype none
// fpu_seq_pkg: shared encodings and response record for the fpu request sequencer.
package fpu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  localparam int FLAG_INF          = 0;
  localparam int FLAG_SNAN         = 1;
  localparam int FLAG_QNAN         = 2;
  localparam int FLAG_INE          = 3;
  localparam int FLAG_OVERFLOW     = 4;
  localparam int FLAG_UNDERFLOW    = 5;
  localparam int FLAG_ZERO         = 6;
  localparam int FLAG_DIV_BY_ZERO  = 7;
  localparam int FLAG_ILLEGAL_OP   = 8;

  typedef struct packed {
    logic [8:0]  flags;
    logic [31:0] data;
  } fpu_rsp_t;

  // Encodings 4..7 are reserved; only the top bit distinguishes them.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_seq_fifo.sv
`default_nettype none
// fpu_seq_fifo: power-of-two synchronous FIFO with occupancy count.
module fpu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             full, do_push, do_pop;

  // Extra pointer bit separates full from empty when the indices match.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/fpu_req_sequencer.sv
`default_nettype none
// fpu_req_sequencer: valid/ready front-end for the fixed-latency fpu core; tracks
// in-flight ops, queues tagged results in order and keeps sticky exception flags.
module fpu_req_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [1:0]       req_rmode,
  input  logic [31:0]      req_opa,
  input  logic [31:0]      req_opb,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_opa,
  output logic [31:0]      fpu_opb,
  output logic [2:0]       fpu_op,
  output logic [1:0]       fpu_rmode,
  input  logic [31:0]      fpu_out,
  input  logic [7:0]       fpu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [8:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [8:0]       sticky_flags,
  input  logic             sticky_clr
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = $bits(fpu_rsp_t) + TAG_W;
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);

  logic               live_q;
  logic [LATENCY-1:0] pipe_vld_q;
  logic [TAG_W:0]     pipe_info_q [LATENCY];
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [8:0]         sticky_q, sticky_d;
  logic [31:0]        opa_q, opb_q;
  logic [2:0]         op_q;
  logic [1:0]         rmode_q;
  logic [CNT_W:0]     credit_used;
  logic               accept, wr_en, pop, fifo_empty;
  fpu_rsp_t           wr_rsp, rd_rsp;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  // Credit covers both in-flight and queued results so the FIFO can never overflow.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign req_ready   = live_q && (credit_used < CREDIT_MAX);
  assign accept      = req_valid && req_ready;

  assign wr_en    = pipe_vld_q[LATENCY-1];
  assign wr_rsp   = '{flags: {pipe_info_q[LATENCY-1][0], fpu_flags}, data: fpu_out};
  assign wr_entry = {pipe_info_q[LATENCY-1][TAG_W:1], wr_rsp};

  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign rd_rsp    = rd_entry[$bits(fpu_rsp_t)-1:0];
  assign rsp_data  = fifo_empty ? '0 : rd_rsp.data;
  assign rsp_flags = fifo_empty ? '0 : rd_rsp.flags;
  assign rsp_tag   = fifo_empty ? '0 : rd_entry[ENTRY_W-1:$bits(fpu_rsp_t)];

  assign fpu_opa      = opa_q;
  assign fpu_opb      = opb_q;
  assign fpu_op       = op_q;
  assign fpu_rmode    = rmode_q;
  assign sticky_flags = sticky_q;

  always_comb begin
    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(wr_en);
    sticky_d   = (sticky_clr ? 9'd0 : sticky_q) | (wr_en ? wr_rsp.flags : 9'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q     <= 1'b0;
      pipe_vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_info_q[i] <= '0;
      inflight_q <= '0;
      sticky_q   <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      op_q       <= '0;
      rmode_q    <= '0;
    end else begin
      live_q         <= 1'b1;
      pipe_vld_q[0]  <= accept;
      pipe_info_q[0] <= {req_tag, is_illegal_op(req_op)};
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_info_q[i] <= pipe_info_q[i-1];
      end
      inflight_q <= inflight_d;
      sticky_q   <= sticky_d;
      if (accept) begin
        opa_q   <= req_opa;
        opb_q   <= req_opb;
        op_q    <= req_op;
        rmode_q <= req_rmode;
      end
    end
  end

  fpu_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_en),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (rd_entry),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_fpu_req_sequencer.sv
`default_nettype none
// Bench for fpu_req_sequencer with a stand-in 4-cycle fpu core and a queue-based
// scoreboard of expected responses, credit and sticky flags.
module tb_fpu_req_sequencer;
  import fpu_seq_pkg::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [1:0]    req_rmode = '0;
  logic [31:0]   req_opa = '0, req_opb = '0;
  logic [TW-1:0] req_tag = '0;
  logic [31:0]   fpu_opa, fpu_opb, fpu_out;
  logic [2:0]    fpu_op;
  logic [1:0]    fpu_rmode;
  logic [7:0]    fpu_flags;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_data;
  logic [8:0]    rsp_flags, sticky_flags;
  logic [TW-1:0] rsp_tag;
  logic          sticky_clr = 1'b0;

  always #5 clk = ~clk;

  fpu_req_sequencer #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rmode(req_rmode),
    .req_opa(req_opa), .req_opb(req_opb), .req_tag(req_tag),
    .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
  );

  // Stand-in core: known IEEE cases for the directed vectors, a scramble otherwise.
  function automatic logic [39:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return {8'h00, 32'h40400000};
    if (op == OP_SUB && a == b) return {8'h40, 32'h00000000};
    if (op == OP_DIV && b == 32'h0) return {8'h81, 32'h7F800000};
    if (op == OP_MUL && a == 32'h40000000 && b == 32'h40400000) return {8'h00, 32'h40C00000};
    return {a[7:0] ^ b[15:8], a ^ {b[15:0], b[31:16]}};
  endfunction

  logic [66:0] h0 = '0, h1 = '0, h2 = '0;
  always @(posedge clk) begin
    h0 <= {fpu_opa, fpu_opb, fpu_op};
    h1 <= h0;
    h2 <= h1;
  end
  assign {fpu_flags, fpu_out} = core_fn(h2[66:35], h2[34:3], h2[2:0]);

  typedef struct {
    logic [TW-1:0] tag;
    logic [8:0]    flags;
    logic [31:0]   data;
    int            wr_edge;
  } exp_t;

  typedef struct {
    logic [2:0]    op;
    logic [1:0]    rmode;
    logic [31:0]   a, b;
    logic [TW-1:0] tag;
    logic [31:0]   exp_data;
    logic [8:0]    exp_flags;
  } vec_t;

  exp_t        q[$];
  vec_t        vt [5];
  int          edge_n = 0;
  int          outstanding = 0;
  bit          live_m = 1'b0;
  logic [8:0]  sticky_m = '0;
  logic [31:0] m_opa = '0, m_opb = '0;
  logic [2:0]  m_op = '0;
  logic [1:0]  m_rmode = '0;
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    outstanding = 0;
    live_m      = 1'b0;
    sticky_m    = '0;
    m_opa = '0; m_opb = '0; m_op = '0; m_rmode = '0;
  endfunction

  function automatic void check_zero(input string tagname);
    chk({tagname, "_req_ready"}, req_ready, 0);
    chk({tagname, "_rsp_valid"}, rsp_valid, 0);
    chk({tagname, "_rsp_data"}, rsp_data, 0);
    chk({tagname, "_rsp_flags"}, rsp_flags, 0);
    chk({tagname, "_rsp_tag"}, rsp_tag, 0);
    chk({tagname, "_sticky"}, sticky_flags, 0);
    chk({tagname, "_fpu_opa"}, fpu_opa, 0);
    chk({tagname, "_fpu_opb"}, fpu_opb, 0);
    chk({tagname, "_fpu_op"}, fpu_op, 0);
    chk({tagname, "_fpu_rmode"}, fpu_rmode, 0);
  endfunction

  // One clock: compare outputs with the model, then advance the model across the edge.
  task automatic step();
    bit          exp_ready, exp_valid, acc, pop;
    logic [39:0] r;
    exp_t        e;
    exp_ready = live_m && (outstanding < DEPTH);
    exp_valid = (q.size() > 0) && (q[0].wr_edge <= edge_n);
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, exp_valid);
    if (exp_valid) begin
      chk("rsp_data", rsp_data, q[0].data);
      chk("rsp_flags", rsp_flags, q[0].flags);
      chk("rsp_tag", rsp_tag, q[0].tag);
    end
    chk("sticky_flags", sticky_flags, sticky_m);
    chk("fpu_opa", fpu_opa, m_opa);
    chk("fpu_opb", fpu_opb, m_opb);
    chk("fpu_op", fpu_op, m_op);
    chk("fpu_rmode", fpu_rmode, m_rmode);
    acc = req_valid && exp_ready;
    pop = rsp_ready && exp_valid;
    @(posedge clk);
    edge_n++;
    if (sticky_clr) sticky_m = '0;
    foreach (q[i]) if (q[i].wr_edge == edge_n) sticky_m |= q[i].flags;
    if (pop) begin
      void'(q.pop_front());
      outstanding--;
    end
    if (acc) begin
      r         = core_fn(req_opa, req_opb, req_op);
      e.tag     = req_tag;
      e.flags   = {req_op >= 3'd4, r[39:32]};
      e.data    = r[31:0];
      e.wr_edge = edge_n + LAT;
      q.push_back(e);
      outstanding++;
      m_opa = req_opa; m_opb = req_opb; m_op = req_op; m_rmode = req_rmode;
    end
    live_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] rm, input logic [31:0] a,
                      input logic [31:0] b, input logic [TW-1:0] tag);
    int guard;
    guard = 0;
    req_valid = 1'b1; req_op = op; req_rmode = rm; req_opa = a; req_opb = b; req_tag = tag;
    while (!req_ready && guard < 32) begin
      step();
      guard++;
    end
    if (guard >= 32) chk("send_timeout_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    send(v.op, v.rmode, v.a, v.b, v.tag);
    n = 0;
    while (!rsp_valid && n < 12) begin
      step();
      n++;
    end
    chk("vec_latency", n, LAT);
    chk("vec_data", rsp_data, v.exp_data);
    chk("vec_flags", rsp_flags, v.exp_flags);
    chk("vec_tag", rsp_tag, v.tag);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc, ntag;
    bit acc;
    vt[0] = '{OP_ADD, 2'd0, 32'h3F800000, 32'h40000000, 4'd5, 32'h40400000, 9'h000};
    vt[1] = '{OP_DIV, 2'd0, 32'h3F800000, 32'h00000000, 4'd1, 32'h7F800000, 9'h081};
    vt[2] = '{3'd6,   2'd1, 32'h12345678, 32'h00000000, 4'd2, 32'h12345678, 9'h178};
    vt[3] = '{OP_SUB, 2'd2, 32'h3F800000, 32'h3F800000, 4'd3, 32'h00000000, 9'h040};
    vt[4] = '{OP_MUL, 2'd3, 32'h40000000, 32'h40400000, 4'd4, 32'h40C00000, 9'h000};

    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n     = 1'b1;
    rsp_ready = 1'b1;

    foreach (vt[i]) run_vec(vt[i]);
    chk("sticky_illegal", sticky_flags[8], 1);

    sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
    chk("sticky_cleared", sticky_flags, 0);
    run_vec(vt[1]);
    chk("sticky_div", sticky_flags[7], 1);
    run_vec(vt[0]);
    run_vec(vt[4]);
    chk("sticky_hold", sticky_flags[7], 1);
    sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
    chk("sticky_after_clr", sticky_flags, 0);

    // Clear lands on the same edge as the zero-result write.
    run_vec(vt[1]);
    send(OP_SUB, 2'd0, 32'h3F800000, 32'h3F800000, 4'd7);
    repeat (3) step();
    sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
    chk("sticky_clr_vs_write", sticky_flags, 9'h040);
    repeat (2) step();

    // Backpressure: credit limits acceptance to FIFO_DEPTH.
    rsp_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = (nacc < 6);
      req_op    = OP_ADD;
      req_opa   = $urandom;
      req_opb   = $urandom;
      req_tag   = TW'(nacc);
      acc       = req_ready && req_valid;
      step();
      if (acc) begin
        nacc++;
        if (nacc == 4) chk("bp_ready_drop", req_ready, 0);
      end
    end
    req_valid = 1'b0;
    chk("bp_accepts", nacc, 4);
    rsp_ready = 1'b1;
    ntag = 0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid) begin
        chk("bp_order", rsp_tag, ntag);
        ntag++;
      end
      step();
    end
    chk("bp_count", ntag, 4);

    // Reset with one queued and three in flight.
    rsp_ready = 1'b0;
    send(OP_MUL, 2'd0, 32'h40000000, 32'h40400000, 4'd9);
    repeat (4) step();
    send(OP_ADD, 2'd0, $urandom, $urandom, 4'd10);
    send(OP_SUB, 2'd1, $urandom, $urandom, 4'd11);
    send(OP_DIV, 2'd2, $urandom, 32'h0, 4'd12);
    chk("pre_reset_sticky_nonzero", sticky_flags != 9'd0, 1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    repeat (8) step();
    run_vec(vt[0]);

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_op    = 3'($urandom_range(0, 7));
      req_rmode = 2'($urandom_range(0, 3));
      req_tag   = TW'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        req_opa = 32'h3F800000;
        req_opb = ($urandom_range(0, 1) == 1) ? 32'h0 : 32'h3F800000;
      end else begin
        req_opa = $urandom;
        req_opb = $urandom;
      end
      rsp_ready  = ($urandom_range(0, 9) < 6);
      sticky_clr = ($urandom_range(0, 19) == 0);
      step();
    end
    req_valid  = 1'b0;
    sticky_clr = 1'b0;
    rsp_ready  = 1'b1;
    repeat (12) step();
    chk("final_rsp_valid", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
